// File: rtl/counter_pkg.sv
// Shared counting helpers: direction encoding and the wrap/saturate next-count function.
// Arithmetic runs in CALC_W bits so any count width up to 64 bits can use it.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // One guard bit above the widest supported count, so MAX_VAL = 2**64-1 cannot overflow.
  localparam int CALC_W = 65;

  typedef logic [CALC_W-1:0] calc_t;

  typedef struct packed {
    calc_t value;
    logic  tc;
  } next_t;

  function automatic next_t next_count(input calc_t cnt,
                                       input calc_t step,
                                       input calc_t max_val,
                                       input logic  dir,
                                       input logic  sat);
    next_t r;
    calc_t modulus;
    calc_t sum;
    modulus = max_val + calc_t'(1);
    sum     = cnt + step;
    r.tc    = 1'b0;
    r.value = cnt;
    case (dir)
      DIR_UP: begin
        if (sum > max_val) begin
          r.tc    = 1'b1;
          r.value = sat ? max_val : sum - modulus;
        end else begin
          r.value = sum;
        end
      end
      DIR_DOWN: begin
        if (cnt < step) begin
          r.tc    = 1'b1;
          r.value = sat ? '0 : cnt + modulus - step;
        end else begin
          r.value = cnt - step;
        end
      end
      default: r.value = cnt;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/count_flags.sv
// Status flags derived combinationally from the registered count.
module count_flags #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] count,
  output logic             parity,
  output logic             nonzero
);

  assign parity  = ^count;
  assign nonzero = |count;

endmodule

// File: rtl/mod_step_counter.sv
// Modulo up/down counter with programmable step, sync clear/load and a registered tc pulse.
// Define COUNTER_SAT_EN to saturate at 0 / MAX_VAL instead of wrapping.
module mod_step_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter int               STEP_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              en,
  input  logic              up,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  count,
  output logic              parity,
  output logic              nonzero,
  output logic              tc
);

`ifdef COUNTER_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  if (WIDTH < 2 || WIDTH > CALC_W - 1) begin : g_bad_width
    $error("mod_step_counter: WIDTH must be in 2..%0d", CALC_W - 1);
  end
  if (((calc_t'(1) << STEP_W) - calc_t'(1)) > calc_t'(MAX_VAL)) begin : g_bad_step
    $error("mod_step_counter: largest step exceeds MAX_VAL");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  next_t            nxt;
  logic             unused_hi;

  always_comb begin
    nxt = next_count(calc_t'(count_q), calc_t'(step), calc_t'(MAX_VAL), up, SAT_EN);
  end

  // The function keeps the count within 0..MAX_VAL, so the guard bits are always zero.
  assign unused_hi = ^nxt.value[CALC_W-1:WIDTH];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      count_d = nxt.value[WIDTH-1:0];
      tc_d    = nxt.tc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;

  count_flags #(.WIDTH(WIDTH)) u_flags (
    .count  (count_q),
    .parity (parity),
    .nonzero(nonzero)
  );

endmodule

// File: tb/tb_mod_step_counter.sv
// Self-checking bench for mod_step_counter (WIDTH=8, MAX_VAL=9, STEP_W=2), both builds.
module tb_mod_step_counter;

  localparam int         W    = 8;
  localparam logic [7:0] MAXV = 8'd9;
  localparam int         SW   = 2;
`ifdef COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          load = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic          en = 1'b0;
  logic          up = 1'b1;
  logic [SW-1:0] step = '0;
  logic [W-1:0]  count;
  logic          parity, nonzero, tc;

  int errors = 0;
  int checks = 0;

  // Reference model: plain integer arithmetic on the counting rules.
  int m_cnt = 0;
  bit m_tc  = 1'b0;

  mod_step_counter #(.WIDTH(W), .MAX_VAL(MAXV), .STEP_W(SW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .load    (load),
    .load_val(load_val),
    .en      (en),
    .up      (up),
    .step    (step),
    .count   (count),
    .parity  (parity),
    .nonzero (nonzero),
    .tc      (tc)
  );

  always #5 clk = ~clk;

  function automatic void model_update();
    int modulus;
    int s;
    modulus = int'(MAXV) + 1;
    if (!rst_n) begin
      m_cnt = 0; m_tc = 1'b0;
    end else if (clear) begin
      m_cnt = 0; m_tc = 1'b0;
    end else if (load) begin
      m_cnt = (int'(load_val) > int'(MAXV)) ? int'(MAXV) : int'(load_val);
      m_tc  = 1'b0;
    end else if (en && up) begin
      s    = m_cnt + int'(step);
      m_tc = (s >= modulus);
      m_cnt = (m_tc && SAT) ? int'(MAXV) : s % modulus;
    end else if (en) begin
      s    = m_cnt - int'(step);
      m_tc = (s < 0);
      m_cnt = (m_tc && SAT) ? 0 : (s + modulus) % modulus;
    end else begin
      m_tc = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_load(input int v);
    clear = 1'b0; en = 1'b0; load = 1'b1; load_val = W'(v);
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    if ({count, tc, parity, nonzero} !== {8'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset_state: got count=%0d tc=%0b par=%0b nz=%0b, want 0 0 0 0",
               count, tc, parity, nonzero);
    end
    checks++;
    rst_n = 1'b1;
    tick();
    if (count !== 8'd0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got count=%0d tc=%0b, want 0 0", count, tc);
    end
    checks++;
  endtask

  task automatic test_reset_mid_count();
    do_load(7);
    if (count !== 8'd7 || parity !== 1'b1 || nonzero !== 1'b1) begin
      errors++;
      $display("FAIL mid_load7: got count=%0d par=%0b nz=%0b, want 7 1 1", count, parity, nonzero);
    end
    checks++;
    #2 rst_n = 1'b0;
    #1;
    if ({count, tc, parity, nonzero} !== {8'd0, 3'b000}) begin
      errors++;
      $display("FAIL mid_reset_async: got count=%0d tc=%0b par=%0b nz=%0b, want 0 0 0 0",
               count, tc, parity, nonzero);
    end
    checks++;
    m_cnt = 0; m_tc = 1'b0;
    #1 rst_n = 1'b1;
    en = 1'b1; up = 1'b1; step = 2'd1;
    tick();
    en = 1'b0;
    if (count !== 8'd1) begin
      errors++;
      $display("FAIL first_edge_after_reset: got count=%0d, want 1", count);
    end
    checks++;
  endtask

  task automatic test_up_wrap();
    do_load(8);
    en = 1'b1; up = 1'b1; step = 2'd3;
    tick();
    if (count !== (SAT ? 8'd9 : 8'd1) || tc !== 1'b1) begin
      errors++;
      $display("FAIL up_wrap: got count=%0d tc=%0b, want %0d 1", count, tc, SAT ? 9 : 1);
    end
    checks++;
    step = 2'd1;
    tick();
    if (count !== (SAT ? 8'd9 : 8'd2) || tc !== SAT) begin
      errors++;
      $display("FAIL up_after_wrap: got count=%0d tc=%0b, want %0d %0b", count, tc, SAT ? 9 : 2, SAT);
    end
    checks++;
    step = 2'd0;
    tick();
    if (count !== (SAT ? 8'd9 : 8'd2) || tc !== 1'b0) begin
      errors++;
      $display("FAIL step_zero_hold: got count=%0d tc=%0b, want %0d 0", count, tc, SAT ? 9 : 2);
    end
    checks++;
    en = 1'b0;
  endtask

  task automatic test_down_wrap();
    do_load(1);
    en = 1'b1; up = 1'b0; step = 2'd2;
    tick();
    if (count !== (SAT ? 8'd0 : 8'd9) || tc !== 1'b1) begin
      errors++;
      $display("FAIL down_wrap: got count=%0d tc=%0b, want %0d 1", count, tc, SAT ? 0 : 9);
    end
    checks++;
    en = 1'b0;
    tick();
    if (tc !== 1'b0 || count !== (SAT ? 8'd0 : 8'd9)) begin
      errors++;
      $display("FAIL tc_one_cycle: got count=%0d tc=%0b, want %0d 0", count, tc, SAT ? 0 : 9);
    end
    checks++;
  endtask

  task automatic test_priority_clamp();
    do_load(4);
    clear = 1'b1; load = 1'b1; load_val = 8'd6; en = 1'b1; up = 1'b1; step = 2'd1;
    tick();
    if (count !== 8'd0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL clear_priority: got count=%0d tc=%0b, want 0 0", count, tc);
    end
    checks++;
    clear = 1'b0; load_val = 8'd3;
    tick();
    if (count !== 8'd3) begin
      errors++;
      $display("FAIL load_over_en: got count=%0d, want 3", count);
    end
    checks++;
    clear = 1'b0; en = 1'b0;
    do_load(200);
    if (count !== 8'd9 || tc !== 1'b0) begin
      errors++;
      $display("FAIL load_clamp_200: got count=%0d tc=%0b, want 9 0", count, tc);
    end
    checks++;
    do_load(10);
    if (count !== 8'd9) begin
      errors++;
      $display("FAIL load_clamp_10: got count=%0d, want 9", count);
    end
    checks++;
  endtask

  task automatic test_flags();
    do_load(5);
    if (parity !== 1'b0 || nonzero !== 1'b1) begin
      errors++;
      $display("FAIL flags_5: got par=%0b nz=%0b, want 0 1", parity, nonzero);
    end
    checks++;
    do_load(7);
    if (parity !== 1'b1 || nonzero !== 1'b1) begin
      errors++;
      $display("FAIL flags_7: got par=%0b nz=%0b, want 1 1", parity, nonzero);
    end
    checks++;
    do_load(0);
    if (parity !== 1'b0 || nonzero !== 1'b0) begin
      errors++;
      $display("FAIL flags_0: got par=%0b nz=%0b, want 0 0", parity, nonzero);
    end
    checks++;
  endtask

`ifdef COUNTER_SAT_EN
  task automatic test_back_to_back();
    do_load(8);
    en = 1'b1; up = 1'b1; step = 2'd3;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (count !== 8'd9 || tc !== 1'b1) begin
        errors++;
        $display("FAIL sat_up_edge%0d: got count=%0d tc=%0b, want 9 1", i, count, tc);
      end
      checks++;
    end
    en = 1'b0;
    do_load(1);
    en = 1'b1; up = 1'b0; step = 2'd3;
    tick();
    if (count !== 8'd0 || tc !== 1'b1) begin
      errors++;
      $display("FAIL sat_down: got count=%0d tc=%0b, want 0 1", count, tc);
    end
    checks++;
    en = 1'b0;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clear    = ($urandom_range(0, 19) == 0);
      load     = ($urandom_range(0, 9) == 0);
      load_val = W'($urandom_range(0, 255));
      en       = ($urandom_range(0, 4) != 0);
      up       = $urandom_range(0, 1) != 0;
      step     = SW'($urandom_range(0, 3));
      tick();
      if (int'(count) !== m_cnt || tc !== m_tc ||
          parity !== 1'($countones(m_cnt) % 2) || nonzero !== (m_cnt != 0)) begin
        errors++;
        $display("FAIL random_%0d: got count=%0d tc=%0b par=%0b nz=%0b, want count=%0d tc=%0b",
                 i, count, tc, parity, nonzero, m_cnt, m_tc);
      end
      checks++;
    end
    clear = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_mid_count();
    test_up_wrap();
    test_down_wrap();
    test_priority_clamp();
    test_flags();
`ifdef COUNTER_SAT_EN
    test_back_to_back();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

endmodule
